bitwise_oper_pipe: RTL

//  Clocked, parametrised successor to the combinational bitwise-operation task.

---
 rtl/bitwise_pkg.sv | 35 +++
 rtl/bitwise_pipe_stage.sv | 44 ++++
 rtl/bitwise_oper_pipe.sv | 99 +++++++++
 3 files changed

// File: rtl/bitwise_pkg.sv
// Opcode encoding and the shared bitwise evaluation function for bitwise_oper_pipe.
package bitwise_pkg;

   // Widest operand bitwise_eval handles; callers truncate to their own WIDTH.
   localparam int unsigned MAX_WIDTH = 256;

   typedef enum logic [2:0] {
      OP_AND    = 3'd0,
      OP_OR     = 3'd1,
      OP_XOR    = 3'd2,
      OP_NAND   = 3'd3,
      OP_NOR    = 3'd4,
      OP_XNOR   = 3'd5,
      OP_ANDN   = 3'd6,
      OP_PASS_A = 3'd7
   } op_e;

   function automatic logic [MAX_WIDTH-1:0] bitwise_eval(
      input op_e                  op,
      input logic [MAX_WIDTH-1:0] a,
      input logic [MAX_WIDTH-1:0] b
   );
      case (op)
         OP_AND:    bitwise_eval = a & b;
         OP_OR:     bitwise_eval = a | b;
         OP_XOR:    bitwise_eval = a ^ b;
         OP_NAND:   bitwise_eval = ~(a & b);
         OP_NOR:    bitwise_eval = ~(a | b);
         OP_XNOR:   bitwise_eval = ~(a ^ b);
         OP_ANDN:   bitwise_eval = a & ~b;
         default:   bitwise_eval = a;
      endcase
   endfunction

endpackage

// File: rtl/bitwise_pipe_stage.sv
// One pipeline slot: valid bit plus payload register with valid/ready handshake.
module bitwise_pipe_stage #(
   parameter int unsigned DW = 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [DW-1:0] up_data,
   output logic          dn_valid,
   input  logic          dn_ready,
   output logic [DW-1:0] dn_data
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q,  data_d;

   // Payload only loads on a real beat, so the output keeps its last value when idle.
   always_comb begin
      up_ready = !valid_q || dn_ready;
      valid_d  = valid_q;
      data_d   = data_q;
      if (up_ready) begin
         valid_d = up_valid;
         if (up_valid) begin
            data_d = up_data;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign dn_valid = valid_q;
   assign dn_data  = data_q;

endmodule

// File: rtl/bitwise_oper_pipe.sv
// Pipelined AND/OR/XOR plus opcode-selected result with valid/ready on both sides.
// Optional result flags (res_zero, res_parity) are built when BITWISE_OPER_FLAGS_EN is defined.
module bitwise_oper_pipe
   import bitwise_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNTW  = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ab_and,
   output logic [WIDTH-1:0] ab_or,
   output logic [WIDTH-1:0] ab_xor,
   output logic [WIDTH-1:0] result,
   output logic [CNTW-1:0]  done_count
`ifdef BITWISE_OPER_FLAGS_EN
   ,
   output logic             res_zero,
   output logic             res_parity
`endif
);

`ifdef BITWISE_OPER_FLAGS_EN
   localparam int unsigned FW = 2;
`else
   localparam int unsigned FW = 0;
`endif
   localparam int unsigned PW = 4 * WIDTH + FW;

   logic [WIDTH-1:0] eval_res;
   logic [PW-1:0]    payload;

   // Everything is computed before stage 0; later stages only carry the payload.
   always_comb begin
      eval_res = WIDTH'(bitwise_eval(op_e'(op), MAX_WIDTH'(a), MAX_WIDTH'(b)));
`ifdef BITWISE_OPER_FLAGS_EN
      payload  = {a & b, a | b, a ^ b, eval_res, (eval_res == '0), ^eval_res};
`else
      payload  = {a & b, a | b, a ^ b, eval_res};
`endif
   end

   logic [DEPTH:0] vld;
   logic [DEPTH:0] rdy;
   logic [PW-1:0]  dat [DEPTH+1];

   assign vld[0]     = in_valid;
   assign dat[0]     = payload;
   assign rdy[DEPTH] = out_ready;
   assign in_ready   = rdy[0];

   // Each stage's ready feeds the one above it, giving a combinational ready chain.
   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      bitwise_pipe_stage #(
         .DW (PW)
      ) u_stage (
         .clock    (clock),
         .reset_n  (reset_n),
         .up_valid (vld[k]),
         .up_ready (rdy[k]),
         .up_data  (dat[k]),
         .dn_valid (vld[k+1]),
         .dn_ready (rdy[k+1]),
         .dn_data  (dat[k+1])
      );
   end

   assign out_valid = vld[DEPTH];
`ifdef BITWISE_OPER_FLAGS_EN
   assign {ab_and, ab_or, ab_xor, result, res_zero, res_parity} = dat[DEPTH];
`else
   assign {ab_and, ab_or, ab_xor, result} = dat[DEPTH];
`endif

   logic [CNTW-1:0] done_count_q, done_count_d;

   always_comb begin
      done_count_d = done_count_q + CNTW'(out_valid && out_ready);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         done_count_q <= '0;
      end else begin
         done_count_q <= done_count_d;
      end
   end

   assign done_count = done_count_q;

endmodule
